pmem_responder: RTL and testbench

//  Physical-memory responder for the cache's pmem burst interface.
//  It accepts one 128-bit line read or write at a time from the cache
//  (pmem_read/pmem_write, pmem_address, pmem_wdata).

---
 rtl/pmem_responder.sv | 108 ++++++++++
 tb/tb_pmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory responder for the cache's 128-bit line burst port.
// Optional protocol checker on pmem_err, built only when PMEM_PROTO_CHECK_EN is defined.
module pmem_responder #(
  parameter int DELAY      = 10,
  parameter int LINES_LOG2 = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_err
);

  localparam int CW = (DELAY < 1) ? 1 : $clog2(DELAY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic                    req;
  logic                    accept;
  logic                    done;
  logic                    op_wr_p0;
  logic [LINES_LOG2-1:0]   idx_p0;
  logic [127:0]            wdata_p0;
  logic [127:0]            mem [0:(1<<LINES_LOG2)-1];
  logic                    unused_addr;

  assign req         = pmem_read | pmem_write;
  assign accept      = (state == IDLE) && req;
  assign done        = (state == BUSY) && (cnt == '0);
  assign unused_addr = ^pmem_address;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req)  state_nxt = BUSY;
      BUSY:    if (done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pmem_resp = (state == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              cnt <= '0;
    else if (accept)                        cnt <= CW'(DELAY - 1);
    else if (state == BUSY && cnt != '0)    cnt <= cnt - CW'(1);
  end

  // Request capture: both strobes high is serviced as a write
  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr_p0 <= pmem_write;
      idx_p0   <= pmem_address[LINES_LOG2+3:4];
      wdata_p0 <= pmem_wdata;
    end
  end

  // Completion edge: reset forces IDLE, so an aborted write never lands
  always_ff @(posedge clk) begin
    if (done && op_wr_p0) mem[idx_p0] <= wdata_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  pmem_rdata <= '0;
    else if (done && !op_wr_p0) pmem_rdata <= mem[idx_p0];
  end

`ifdef PMEM_PROTO_CHECK_EN
  logic [11:0] line_p0;
  logic        err_set;

  always_ff @(posedge clk) begin
    if (accept) line_p0 <= pmem_address[15:4];
  end

  always_comb begin
    err_set = 1'b0;
    if (accept && pmem_read && pmem_write) err_set = 1'b1;
    if (state == BUSY) begin
      if (op_wr_p0 ? !pmem_write : !pmem_read) err_set = 1'b1;
      if (pmem_address[15:4] != line_p0)       err_set = 1'b1;
      if (pmem_read && pmem_write)             err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pmem_err <= 1'b0;
    else if (err_set) pmem_err <= 1'b1;
  end
`else
  assign pmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized self-checking bench for pmem_responder against a line-array reference model.
module tb_pmem_responder;

  localparam int DELAY = 10;
  localparam int LL2   = 8;
`ifdef PMEM_PROTO_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         rd, wr;
  logic [15:0]  addr;
  logic [127:0] wdata, rdata;
  logic         resp, err;

  logic         rd1, wr1;
  logic [15:0]  addr1;
  logic [127:0] wdata1, rdata1;
  logic         resp1, err1;

  int checks = 0;
  int errors = 0;

  logic [127:0] model [int];
  logic [127:0] last_rd;
  logic [15:0]  known [$];

  always #5 clk = ~clk;

  pmem_responder #(.DELAY(DELAY), .LINES_LOG2(LL2)) u_dut (
    .clk(clk), .reset(reset), .pmem_read(rd), .pmem_write(wr),
    .pmem_address(addr), .pmem_wdata(wdata), .pmem_rdata(rdata),
    .pmem_resp(resp), .pmem_err(err)
  );

  pmem_responder #(.DELAY(1), .LINES_LOG2(4)) u_dut1 (
    .clk(clk), .reset(reset), .pmem_read(rd1), .pmem_write(wr1),
    .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_rdata(rdata1),
    .pmem_resp(resp1), .pmem_err(err1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [15:0] a);
    return (int'(a) / 16) % (1 << LL2);
  endfunction

  // Called #1 after an edge with the DUT idle; the next edge accepts the request.
  task automatic access(input bit is_wr, input logic [15:0] a, input logic [127:0] d,
                        input int drop_at);
    int lat;
    rd = !is_wr; wr = is_wr; addr = a; wdata = d;
    @(posedge clk); #1;
    lat = 0;
    while (lat < DELAY + 5) begin
      if (lat == drop_at) begin rd = 1'b0; wr = 1'b0; end
      @(posedge clk); #1;
      lat++;
      if (resp) break;
    end
    chk("resp_latency", lat, DELAY);
    if (is_wr) model[line_of(a)] = d;
    else       last_rd = model[line_of(a)];
    chk("rdata_resp", rdata, last_rd);
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    chk("resp_one_cycle", resp, 1'b0);
    chk("rdata_hold", rdata, last_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a5, pre, oldv, newv, q;
    logic [15:0]  a;
    reset = 1'b1; rd = 0; wr = 0; addr = '0; wdata = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", resp, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    a5 = {16{8'hA5}};
    access(1'b1, 16'h0120, a5, -1);
    access(1'b0, 16'h0120, '0, -1);
    chk("read_a5", rdata, a5);

    pre = {4{32'h5540_C0DE}};
    access(1'b1, 16'h5540, pre, -1);
    access(1'b1, 16'h3340, {4{32'h3340_BEEF}}, -1);
    access(1'b0, 16'h5540, '0, -1);
    chk("read_preload", rdata, pre);
    access(1'b0, 16'hF54C, '0, -1);
    chk("read_alias", rdata, pre);

    // Reset four clocks into a write must leave the old line intact
    oldv = {4{32'h0200_0001}};
    newv = {4{32'h0200_FFFF}};
    access(1'b1, 16'h0200, oldv, -1);
    wr = 1'b1; addr = 16'h0200; wdata = newv;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_resp", resp, 1'b0);
    chk("abort_rdata", rdata, '0);
    chk("abort_err", err, 1'b0);
    wr = 1'b0;
    @(posedge clk); #1;
    chk("abort_resp_hold", resp, 1'b0);
    reset = 1'b0;
    last_rd = '0;
    @(posedge clk); #1;
    access(1'b0, 16'h0200, '0, -1);
    chk("abort_old_data", rdata, oldv);

    for (int i = 0; i < 24; i++) begin
      if (known.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = 16'($urandom);
        known.push_back(a);
        access(1'b1, a, {$urandom, $urandom, $urandom, $urandom}, -1);
      end else begin
        a = known[$urandom_range(0, known.size() - 1)];
        a = a ^ (16'($urandom_range(0, 15)) << 12) ^ 16'($urandom_range(0, 15));
        access(1'b0, a, '0, -1);
      end
    end
    chk("rand_err", err, 1'b0);

    // DELAY=1 instance: response in the second cycle, held request re-accepted
    q = {4{32'h1111_2222}};
    wr1 = 1'b1; addr1 = 16'h0030; wdata1 = q;
    @(posedge clk); #1;
    chk("d1_wr_busy", resp1, 1'b0);
    @(posedge clk); #1;
    chk("d1_wr_resp", resp1, 1'b1);
    wr1 = 1'b0;
    @(posedge clk); #1;
    rd1 = 1'b1;
    @(posedge clk); #1;
    chk("d1_rd_busy", resp1, 1'b0);
    @(posedge clk); #1;
    chk("d1_rd_resp", resp1, 1'b1);
    chk("d1_rd_data", rdata1, q);
    @(posedge clk); #1;
    chk("d1_idle", resp1, 1'b0);
    @(posedge clk); #1;
    chk("d1_reaccept_busy", resp1, 1'b0);
    @(posedge clk); #1;
    chk("d1_reaccept_resp", resp1, 1'b1);
    chk("d1_reaccept_data", rdata1, q);
    rd1 = 1'b0;
    @(posedge clk); #1;
    chk("d1_done", resp1, 1'b0);
    chk("d1_err", err1, 1'b0);

    // Read dropped mid-access still completes; error flag is sticky until reset
    access(1'b0, 16'h0120, '0, 3);
    chk("drop_rdata", rdata, a5);
    chk("drop_err", err, ERR_EN);
    repeat (3) @(posedge clk);
    #1;
    chk("drop_err_sticky", err, ERR_EN);
    reset = 1'b1;
    #1;
    chk("err_cleared", err, 1'b0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
